argmax_unit: RTL and testbench

Downstream classifier stage for the MNIST network: after `neural_network` finishes a forward pass, this block scans its output-layer scores one per cycle over a registered read port and reports the winning digit class and its score. It sits between `neural_network` and the board display/LED logic in `top_level`, and turns a bank of signed fixed-point scores into a single 4-bit prediction, a one-hot LED vector and a done pulse.

---
 rtl/nn_pkg.sv | 22 ++
 rtl/argmax_unit.sv | 137 +++++++++++++
 tb/tb_argmax_unit.sv | 350 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/nn_pkg.sv
// nn_pkg: shared constants and types for the MNIST classifier datapath.
//   N_CLASSES - number of output-layer scores
//   SCORE_W   - score width, signed Q8.8
//   score_t   - signed score type
//   class_t   - 4-bit class index type
//   state_e   - argmax_unit FSM states
package nn_pkg;

  localparam int unsigned N_CLASSES = 10;
  localparam int unsigned SCORE_W   = 16;
  localparam int unsigned CLASS_W   = 4;

  typedef logic signed [SCORE_W-1:0] score_t;
  typedef logic [CLASS_W-1:0]        class_t;

  typedef enum logic [1:0] {
    StIdle,
    StScan,
    StDrain
  } state_e;

endpackage

// File: rtl/argmax_unit.sv
// argmax_unit: scans N_CLASSES signed scores from a 1-cycle registered read port and
// reports the index and value of the largest one (lowest index wins on ties).
// Ports:
//   Clk          - system clock
//   Reset        - asynchronous active-high reset
//   Start        - request a scan, honoured only when idle
//   Score_Addr   - score index requested from the source
//   Score_Data   - source data for the previous cycle's Score_Addr
//   Busy         - scan in progress
//   Done         - one-cycle pulse when results update
//   Valid        - at least one scan completed since reset
//   Class        - index of the maximum score
//   Max_Score    - value of the maximum score
//   Class_Onehot - one-hot decode of Class (all zero until Valid)
module argmax_unit #(
  parameter int unsigned N_CLASSES = nn_pkg::N_CLASSES,
  parameter int unsigned SCORE_W   = nn_pkg::SCORE_W,
  localparam int unsigned AW       = $clog2(N_CLASSES)
) (
  input  logic                      Clk,
  input  logic                      Reset,
  input  logic                      Start,
  output logic [AW-1:0]             Score_Addr,
  input  logic signed [SCORE_W-1:0] Score_Data,
  output logic                      Busy,
  output logic                      Done,
  output logic                      Valid,
  output nn_pkg::class_t            Class,
  output logic [SCORE_W-1:0]        Max_Score,
  output logic [N_CLASSES-1:0]      Class_Onehot
);

  import nn_pkg::*;

  localparam logic [AW-1:0] LastIdx = AW'(N_CLASSES - 1);

  state_e                    r_state, w_state_next;
  logic [AW-1:0]             r_cnt, w_cnt_next;

  // Read pipeline tag: the address issued last cycle and whether it was a real read.
  logic                      r_rd_vld;
  class_t                    r_rd_idx;

  logic signed [SCORE_W-1:0] r_run_max, w_run_max;
  class_t                    r_run_idx, w_run_idx;
  logic                      w_take;

  logic                      r_done;
  logic                      r_valid;
  class_t                    r_class;
  logic signed [SCORE_W-1:0] r_max;

  // FSM state register
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state <= StIdle;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  // FSM next state, address counter and status outputs
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    Score_Addr   = '0;
    Busy         = 1'b1;
    unique case (r_state)
      StIdle: begin
        Busy = 1'b0;
        if (Start) begin
          w_state_next = StScan;
          w_cnt_next   = '0;
        end
      end
      StScan: begin
        Score_Addr = r_cnt;
        if (r_cnt == LastIdx) begin
          w_state_next = StDrain;
        end else begin
          w_cnt_next = r_cnt + AW'(1);
        end
      end
      StDrain: begin
        w_state_next = StIdle;
      end
      default: begin
        w_state_next = StIdle;
      end
    endcase
  end

  // Index 0 loads unconditionally so no sentinel is needed; strict '>' keeps the
  // lowest index on ties.
  always_comb begin
    w_take    = r_rd_vld && ((r_rd_idx == '0) || (Score_Data > r_run_max));
    w_run_max = w_take ? Score_Data : r_run_max;
    w_run_idx = w_take ? r_rd_idx : r_run_idx;
  end

  // Datapath: read tag pipeline, running max, committed results
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_rd_vld  <= 1'b0;
      r_rd_idx  <= '0;
      r_run_max <= '0;
      r_run_idx <= '0;
      r_done    <= 1'b0;
      r_valid   <= 1'b0;
      r_class   <= '0;
      r_max     <= '0;
    end else begin
      r_rd_vld  <= (r_state == StScan);
      r_rd_idx  <= class_t'(r_cnt);
      r_run_max <= w_run_max;
      r_run_idx <= w_run_idx;
      r_done    <= (r_state == StDrain);
      // The last score arrives during DRAIN, so commit the bypassed running result.
      if (r_state == StDrain) begin
        r_valid <= 1'b1;
        r_class <= w_run_idx;
        r_max   <= w_run_max;
      end
    end
  end

  assign Done      = r_done;
  assign Valid     = r_valid;
  assign Class     = r_class;
  assign Max_Score = r_max;

  // Gated by Valid so the LEDs stay dark after reset instead of showing class 0.
  assign Class_Onehot = r_valid ? (N_CLASSES'(1) << r_class) : '0;

endmodule

// File: tb/tb_argmax_unit.sv
// tb_argmax_unit: self-checking bench for argmax_unit with a registered-read score source
// and a queue of expected {Class, Max_Score} results.
module tb_argmax_unit;

  logic               Clk = 1'b0;
  logic               Reset;
  logic               Start;
  logic [3:0]         Score_Addr;
  logic signed [15:0] Score_Data;
  logic               Busy;
  logic               Done;
  logic               Valid;
  logic [3:0]         Class;
  logic [15:0]        Max_Score;
  logic [9:0]         Class_Onehot;

  typedef struct packed {
    logic [3:0]  cls;
    logic [15:0] mx;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] mem [10];
  int          n_tests = 0;
  int          n_fail  = 0;

  argmax_unit dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .Start        (Start),
    .Score_Addr   (Score_Addr),
    .Score_Data   (Score_Data),
    .Busy         (Busy),
    .Done         (Done),
    .Valid        (Valid),
    .Class        (Class),
    .Max_Score    (Max_Score),
    .Class_Onehot (Class_Onehot)
  );

  always #5 Clk = ~Clk;

  // Score source: 1-cycle registered read
  always @(posedge Clk) Score_Data <= mem[Score_Addr];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1);
  end

  task automatic start_scan();
    Start = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int lat);
    lat = -1;
    for (int k = 0; k < budget; k++) begin
      if (Done === 1'b1) begin
        lat = k;
        break;
      end
      @(negedge Clk);
    end
  endtask

  task automatic pop_exp(output exp_t e, output bit ok);
    ok = (sb.size() > 0);
    e  = '0;
    if (ok) e = sb.pop_front();
  endtask

  function automatic logic [30:0] result_of(input exp_t e);
    logic [9:0] oh;
    oh = 10'd1 << e.cls;
    return {1'b1, e.cls, e.mx, oh};
  endfunction

  task automatic test_reset();
    logic [37:0] got;
    Reset = 1'b1;
    Start = 1'b0;
    repeat (2) @(negedge Clk);
    got = {Score_Addr, Busy, Done, Valid, Class, Max_Score, Class_Onehot};
    n_tests++;
    if (got !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h want 0", got);
    end
    Reset = 1'b0;
    @(negedge Clk);
  endtask

  task automatic test_basic();
    exp_t e;
    bit ok;
    logic [30:0] got;
    mem = '{16'h0010, 16'h0200, 16'h0050, 16'h0000, 16'h0000,
            16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
    sb.push_back('{cls: 4'd1, mx: 16'h0200});
    start_scan();
    for (int k = 0; k < 10; k++) begin
      n_tests++;
      if (Score_Addr !== 4'(k) || Busy !== 1'b1) begin
        n_fail++;
        $display("FAIL basic_addr[%0d]: got addr %0d busy %b want addr %0d busy 1",
                 k, Score_Addr, Busy, k);
      end
      @(negedge Clk);
    end
    n_tests++;
    if (Done !== 1'b0 || Busy !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_drain: got done %b busy %b want done 0 busy 1", Done, Busy);
    end
    @(negedge Clk);
    n_tests++;
    if (Done !== 1'b1 || Busy !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_done_lat11: got done %b busy %b want done 1 busy 0", Done, Busy);
    end
    pop_exp(e, ok);
    got = {Valid, Class, Max_Score, Class_Onehot};
    n_tests++;
    if (!ok || got !== result_of(e)) begin
      n_fail++;
      $display("FAIL basic_result: got %h want %h", got, result_of(e));
    end
    @(negedge Clk);
    n_tests++;
    if (Done !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_done_pulse: got %b want 0", Done);
    end
  endtask

  task automatic test_negative();
    exp_t e;
    bit ok;
    int lat;
    logic [30:0] got;
    mem = '{16'hFFFB, 16'hFFFD, 16'hFFF7, 16'hFFFC, 16'hFFFA,
            16'hFFF8, 16'hFFF6, 16'hFFEC, 16'hFF9C, 16'hFFF9};
    sb.push_back('{cls: 4'd1, mx: 16'hFFFD});
    start_scan();
    wait_done(20, lat);
    n_tests++;
    if (lat != 11) begin
      n_fail++;
      $display("FAIL negative_latency: got %0d want 11", lat);
    end
    pop_exp(e, ok);
    got = {Valid, Class, Max_Score, Class_Onehot};
    n_tests++;
    if (!ok || got !== result_of(e)) begin
      n_fail++;
      $display("FAIL negative_result: got %h want %h", got, result_of(e));
    end
    @(negedge Clk);
  endtask

  task automatic test_ties();
    exp_t e;
    bit ok;
    int lat;
    logic [30:0] got;
    mem = '{16'h0000, 16'h0000, 16'h0000, 16'h7FFF, 16'h0000,
            16'h0000, 16'h0000, 16'h7FFF, 16'h0000, 16'h0000};
    sb.push_back('{cls: 4'd3, mx: 16'h7FFF});
    start_scan();
    repeat (6) @(negedge Clk);
    // Previous result (negative test) must still be shown mid-scan
    n_tests++;
    if (Class !== 4'd1 || Max_Score !== 16'hFFFD || Valid !== 1'b1) begin
      n_fail++;
      $display("FAIL ties_hold_prev: got class %0d max %h valid %b want class 1 max fffd valid 1",
               Class, Max_Score, Valid);
    end
    wait_done(20, lat);
    n_tests++;
    if (lat != 5) begin
      n_fail++;
      $display("FAIL ties_latency: got %0d want 5 (11 after start)", lat);
    end
    pop_exp(e, ok);
    got = {Valid, Class, Max_Score, Class_Onehot};
    n_tests++;
    if (!ok || got !== result_of(e)) begin
      n_fail++;
      $display("FAIL ties_result: got %h want %h", got, result_of(e));
    end
    @(negedge Clk);
  endtask

  task automatic test_ignore_start();
    exp_t e;
    bit ok;
    int nd;
    int dk;
    logic [30:0] got;
    mem = '{16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'h0100,
            16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'h0400};
    sb.push_back('{cls: 4'd9, mx: 16'h0400});
    start_scan();
    nd = 0;
    dk = -1;
    for (int k = 0; k < 30; k++) begin
      Start = (k == 3 || k == 5);
      if (Done === 1'b1) begin
        nd++;
        dk = k;
        pop_exp(e, ok);
        got = {Valid, Class, Max_Score, Class_Onehot};
        n_tests++;
        if (!ok || got !== result_of(e)) begin
          n_fail++;
          $display("FAIL ignore_result: got %h want %h", got, result_of(e));
        end
      end
      @(negedge Clk);
    end
    Start = 1'b0;
    n_tests++;
    if (nd != 1 || dk != 11) begin
      n_fail++;
      $display("FAIL ignore_single_done: got %0d dones last at %0d want 1 done at 11", nd, dk);
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    bit ok;
    int nd;
    int d0;
    int d1;
    logic [30:0] got;
    mem = '{16'h0100, 16'h0000, 16'h0000, 16'h0000, 16'h0000,
            16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
    sb.push_back('{cls: 4'd0, mx: 16'h0100});
    sb.push_back('{cls: 4'd9, mx: 16'h0001});
    Start = 1'b1;
    @(negedge Clk);
    nd = 0;
    d0 = -1;
    d1 = -1;
    for (int k = 0; k < 30; k++) begin
      if (k == 12) begin
        n_tests++;
        if (Busy !== 1'b1) begin
          n_fail++;
          $display("FAIL b2b_restart: got busy %b want 1", Busy);
        end
        Start  = 1'b0;
        mem[0] = 16'h0000;
        mem[9] = 16'h0001;
      end
      if (Done === 1'b1) begin
        nd++;
        if (nd == 1) d0 = k;
        else d1 = k;
        pop_exp(e, ok);
        got = {Valid, Class, Max_Score, Class_Onehot};
        n_tests++;
        if (!ok || got !== result_of(e)) begin
          n_fail++;
          $display("FAIL b2b_result%0d: got %h want %h", nd, got, result_of(e));
        end
      end
      @(negedge Clk);
    end
    Start = 1'b0;
    n_tests++;
    if (nd != 2 || d0 != 11 || d1 != 23) begin
      n_fail++;
      $display("FAIL b2b_timing: got %0d dones at %0d,%0d want 2 dones at 11,23", nd, d0, d1);
    end
  endtask

  task automatic test_reset_mid_scan();
    exp_t e;
    bit ok;
    int nd;
    int lat;
    logic [37:0] z;
    logic [30:0] got;
    mem = '{16'h0001, 16'h0001, 16'h0001, 16'h0001, 16'h0001,
            16'h0300, 16'h0001, 16'h0001, 16'h0001, 16'h0001};
    start_scan();
    repeat (6) @(negedge Clk);
    Reset = 1'b1;
    #1;
    z = {Score_Addr, Busy, Done, Valid, Class, Max_Score, Class_Onehot};
    n_tests++;
    if (z !== '0) begin
      n_fail++;
      $display("FAIL midreset_async_clear: got %h want 0", z);
    end
    repeat (2) @(negedge Clk);
    Reset = 1'b0;
    nd = 0;
    for (int k = 0; k < 15; k++) begin
      if (Done === 1'b1) nd++;
      @(negedge Clk);
    end
    n_tests++;
    if (nd != 0 || Valid !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_no_done: got %0d dones valid %b want 0 dones valid 0", nd, Valid);
    end
    sb.push_back('{cls: 4'd5, mx: 16'h0300});
    start_scan();
    wait_done(20, lat);
    n_tests++;
    if (lat != 11) begin
      n_fail++;
      $display("FAIL midreset_rescan_latency: got %0d want 11", lat);
    end
    pop_exp(e, ok);
    got = {Valid, Class, Max_Score, Class_Onehot};
    n_tests++;
    if (!ok || got !== result_of(e)) begin
      n_fail++;
      $display("FAIL midreset_rescan_result: got %h want %h", got, result_of(e));
    end
    @(negedge Clk);
  endtask

  initial begin
    Reset = 1'b1;
    Start = 1'b0;
    for (int i = 0; i < 10; i++) mem[i] = 16'h0000;
    test_reset();
    test_basic();
    test_negative();
    test_ties();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid_scan();
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drained: got %0d left want 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
